// File: rtl/ship_laser_controller_pkg.sv
// Shared constants, FSM encoding and launch geometry for the player laser engine.
package ship_laser_controller_pkg;

  localparam logic [9:0] TOP_BOUND  = 10'd35;
  localparam logic [9:0] SHIP_Y     = 10'd480;
  localparam logic [9:0] SHIP_WIDTH = 10'd24;
  localparam logic [9:0] LASER_W    = 10'd2;
  localparam logic [9:0] LASER_H    = 10'd8;
  localparam logic [9:0] LASER_STEP = 10'd4;

  localparam int COOLDOWN_TICKS = 8;
  localparam int CD_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLIGHT   = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  // Laser is centred horizontally on the ship's nose.
  function automatic logic [9:0] launch_x(input logic [9:0] ship_x);
    return ship_x + SHIP_WIDTH / 10'd2 - LASER_W / 10'd2;
  endfunction

endpackage

// File: rtl/ship_laser_controller_fire_edge_detect.sv
// Button level register with a one-cycle rising-edge pulse; reusable for any debounced button.
module ship_laser_controller_fire_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/ship_laser_controller.sv
// Player laser engine: launch from ship nose, step upward per tick, retire on hit/top, then cool down.
// Optional AUTOFIRE_EN: fire level (not edge) launches from IDLE, so a held button keeps refiring.
module ship_laser_controller
  import ship_laser_controller_pkg::*;
(
  input  logic       clk_master,
  input  logic       d_reset,
  input  logic       tick_laser,
  input  logic       d_fire,
  input  logic [9:0] ship_x,
  input  logic       hit,
  output logic [9:0] laser_x,
  output logic [9:0] laser_y,
  output logic       laser_active,
  output logic       laser_fired
);

  state_t          state;
  state_t          state_next;
  logic            fire_edge;
  logic            launch;
  logic            at_top;
  logic [CD_W-1:0] cd_cnt;

  ship_laser_controller_fire_edge_detect u_fire_edge (
    .clk   (clk_master),
    .rst   (d_reset),
    .level (d_fire),
    .rise  (fire_edge)
  );

`ifdef AUTOFIRE_EN
  assign launch = d_fire;
`else
  assign launch = fire_edge;
`endif

  // One more step would cross the first visible line.
  assign at_top = (laser_y < TOP_BOUND + LASER_STEP);

  always_ff @(posedge clk_master or posedge d_reset) begin
    if (d_reset) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (launch) state_next = ST_FLIGHT;
      ST_FLIGHT:   if (hit || (tick_laser && at_top)) state_next = ST_COOLDOWN;
      ST_COOLDOWN: if (cd_cnt == CD_W'(COOLDOWN_TICKS)) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    laser_active = (state == ST_FLIGHT);
  end

  always_ff @(posedge clk_master or posedge d_reset) begin
    if (d_reset) begin
      laser_x     <= '0;
      laser_y     <= '0;
      laser_fired <= 1'b0;
      cd_cnt      <= '0;
    end else begin
      laser_fired <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            laser_x     <= launch_x(ship_x);
            laser_y     <= SHIP_Y - LASER_H;
            laser_fired <= 1'b1;
          end
        end
        ST_FLIGHT: begin
          if (!hit && tick_laser && !at_top) laser_y <= laser_y - LASER_STEP;
        end
        default: ;
      endcase
      // Counter rests at zero outside COOLDOWN, so it is already clear on entry.
      if (state != ST_COOLDOWN) cd_cnt <= '0;
      else if (tick_laser)      cd_cnt <= cd_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ship_laser_controller.sv
// Directed bench for ship_laser_controller with an expected-output scoreboard queue.
module tb_ship_laser_controller;

  logic       clk_master = 1'b0;
  logic       d_reset;
  logic       tick_laser;
  logic       d_fire;
  logic [9:0] ship_x;
  logic       hit;
  logic [9:0] laser_x;
  logic [9:0] laser_y;
  logic       laser_active;
  logic       laser_fired;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
    logic       fired;
  } exp_t;

  exp_t sb[$];

  ship_laser_controller dut (
    .clk_master   (clk_master),
    .d_reset      (d_reset),
    .tick_laser   (tick_laser),
    .d_fire       (d_fire),
    .ship_x       (ship_x),
    .hit          (hit),
    .laser_x      (laser_x),
    .laser_y      (laser_y),
    .laser_active (laser_active),
    .laser_fired  (laser_fired)
  );

  always #5 clk_master = ~clk_master;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_master);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_laser = 1'b1;
      cyc(1);
      tick_laser = 1'b0;
    end
  endtask

  task automatic expect_out(input string tag, input logic a, input logic [9:0] x,
                            input logic [9:0] y, input logic f);
    exp_t e;
    e.tag = tag; e.active = a; e.x = x; e.y = y; e.fired = f;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_empty observed=0 entries expected>=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (laser_active === e.active) else begin
        errors++;
        $error("FAIL %s.active observed=%0b expected=%0b", e.tag, laser_active, e.active);
      end
      checks++;
      assert (laser_x === e.x) else begin
        errors++;
        $error("FAIL %s.x observed=%0d expected=%0d", e.tag, laser_x, e.x);
      end
      checks++;
      assert (laser_y === e.y) else begin
        errors++;
        $error("FAIL %s.y observed=%0d expected=%0d", e.tag, laser_y, e.y);
      end
      checks++;
      assert (laser_fired === e.fired) else begin
        errors++;
        $error("FAIL %s.fired observed=%0b expected=%0b", e.tag, laser_fired, e.fired);
      end
      $display("check %s: active=%0b x=%0d y=%0d fired=%0b", e.tag, laser_active, laser_x,
               laser_y, laser_fired);
    end
  endtask

  initial begin
    d_reset = 1'b1; tick_laser = 1'b0; d_fire = 1'b0; ship_x = 10'd0; hit = 1'b0;
    cyc(2);
    expect_out("reset", 1'b0, 10'd0, 10'd0, 1'b0);
    check_out();
    d_reset = 1'b0;
    cyc(1);

    // Launch from ship_x=300: nose at 311, top of laser at 472.
    ship_x = 10'd300; d_fire = 1'b1;
    expect_out("launch", 1'b1, 10'd311, 10'd472, 1'b1);
    cyc(1);
    check_out();
    expect_out("fired_pulse_end", 1'b1, 10'd311, 10'd472, 1'b0);
    cyc(1);
    check_out();
    d_fire = 1'b0;
    cyc(1);

    // Second edge in flight is dropped; ship movement does not drag the laser.
    ship_x = 10'd100; d_fire = 1'b1;
    expect_out("refire_in_flight", 1'b1, 10'd311, 10'd472, 1'b0);
    cyc(1);
    check_out();
    d_fire = 1'b0;

    expect_out("three_ticks", 1'b1, 10'd311, 10'd460, 1'b0);
    ticks(3);
    check_out();
    expect_out("last_visible_y36", 1'b1, 10'd311, 10'd36, 1'b0);
    ticks(106);
    check_out();
    expect_out("retire_at_top", 1'b0, 10'd311, 10'd36, 1'b0);
    ticks(1);
    check_out();

    // Fire edge during cooldown is dropped.
    d_fire = 1'b1;
    expect_out("refire_in_cooldown", 1'b0, 10'd311, 10'd36, 1'b0);
    cyc(1);
    check_out();
    d_fire = 1'b0;
    cyc(1);

    // After the 8th tick the FSM is still in COOLDOWN for one clock; an edge there is dropped.
    ticks(8);
    d_fire = 1'b1;
    expect_out("edge_at_cd_end", 1'b0, 10'd311, 10'd36, 1'b0);
    cyc(1);
    check_out();
    d_fire = 1'b0;
    cyc(1);

    ship_x = 10'd200; d_fire = 1'b1;
    expect_out("launch2", 1'b1, 10'd211, 10'd472, 1'b1);
    cyc(1);
    check_out();
    d_fire = 1'b0;
    expect_out("y400", 1'b1, 10'd211, 10'd400, 1'b0);
    ticks(18);
    check_out();

    // Hit wins over a coincident tick: no step, retire.
    hit = 1'b1; tick_laser = 1'b1;
    expect_out("hit_with_tick", 1'b0, 10'd211, 10'd400, 1'b0);
    cyc(1);
    check_out();
    tick_laser = 1'b0;
    cyc(1);
    hit = 1'b0;

    // Hold fire through the whole cooldown.
    d_fire = 1'b1;
    ticks(8);
    expect_out("cd_done_idle", 1'b0, 10'd211, 10'd400, 1'b0);
    cyc(1);
    check_out();
`ifdef AUTOFIRE_EN
    expect_out("autofire_relaunch", 1'b1, 10'd211, 10'd472, 1'b1);
    cyc(1);
    check_out();
    d_fire = 1'b0; hit = 1'b1;
    cyc(1);
    hit = 1'b0;
    ticks(8);
    cyc(1);
`else
    expect_out("held_no_refire", 1'b0, 10'd211, 10'd400, 1'b0);
    cyc(3);
    check_out();
    d_fire = 1'b0;
    cyc(1);
`endif

    // Reset mid-flight clears the laser without waiting for a clock.
    ship_x = 10'd50; d_fire = 1'b1;
    expect_out("launch3", 1'b1, 10'd61, 10'd472, 1'b1);
    cyc(1);
    check_out();
    d_fire = 1'b0;
    expect_out("launch3_step", 1'b1, 10'd61, 10'd464, 1'b0);
    ticks(2);
    check_out();
    #2 d_reset = 1'b1;
    expect_out("async_reset", 1'b0, 10'd0, 10'd0, 1'b0);
    #1 check_out();
    #2 d_reset = 1'b0;
    cyc(1);
    d_fire = 1'b1;
    expect_out("launch_after_reset", 1'b1, 10'd61, 10'd472, 1'b1);
    cyc(1);
    check_out();
    d_fire = 1'b0;
    expect_out("post_reset_pulse_end", 1'b1, 10'd61, 10'd472, 1'b0);
    cyc(1);
    check_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
